period_meter_m: RTL and testbench
=================================

// Module: period_meter_m
// PURPOSE
//  Receive-side counterpart of the prescaler: measures the period of a divided/slow input signal
//  (e.g. a prescaler output bit from another clock domain or an external pin) in local clk cycles.
//  Synchronises the input, detects rising edges, counts cycles between edges, publishes a
//  period word with a 1-cycle valid strobe, and flags loss of signal (timeout). Sits in test/bring-up
//  designs next to prescaler_m to close the loop: prescaler drives, period_meter checks.
// PARAMETERS
//  PERIOD_W     16  width of cycle counter and period output; max measurable = 2**PERIOD_W-1
//  SYNC_STAGES  2   synchroniser depth for sig_in (legal: 2..4)
// PORTS
//  clk           in   1         system clock, all logic on posedge
//  rst           in   1         reset, asynchronous, active-high
//  sig_in        in   1         asynchronous signal to measure
//  period        out  PERIOD_W  last measured period in clk cycles (rising edge to rising edge)
//  period_valid  out  1         1-cycle strobe: period updated this cycle
//  locked        out  1         1 while at least one full period measured and no timeout since
//  timeout       out  1         1 while counter saturated without an edge
// BEHAVIOUR
//  Reset (async, immediate, no clk needed): state=IDLE, counter=0, period=0, period_valid=0,
//   locked=0, timeout=0, all synchroniser/edge flops=0. Deassert: normal operation next posedge.
//  Edge detect: sig_s = sig_in after SYNC_STAGES flops; edge = sig_s & ~sig_s_d (registered).
//   Latency sig_in rise -> edge pulse = SYNC_STAGES+1 clk. Only rising edges count.
//  FSM (states IDLE, MEASURE, TIMEOUT), per posedge:
//   IDLE:    counter held 0. edge -> MEASURE, counter=1. No valid on this first edge.
//   MEASURE: no edge -> counter+1; if counter==all-ones and no edge -> TIMEOUT.
//            edge -> period<=counter, period_valid=1 next cycle only, locked<=1, counter<=1.
//   TIMEOUT: timeout=1, locked=0, counter held at all-ones, period keeps last value.
//            edge -> MEASURE, counter=1, timeout<=0; no valid for this edge (restart like IDLE).
//  Simultaneous edge and counter==all-ones in MEASURE: edge wins -> period=all-ones, valid, no timeout.
//  Counter never wraps; saturation is the only overflow response.
//  period holds value between strobes; period_valid never asserted twice in consecutive cycles
//   (minimum reportable period is 2, since sig_s must be low >=1 cycle between rises).
//  Example: sig_in high 8 clk / low 8 clk -> period=16, strobe every 16 clk once locked.
// CONFIGURATION
//  PERIOD_METER_AVG_EN defined: period = floor(mean of last 4 raw measurements).
//   4-entry history + (PERIOD_W+2)-bit running sum; fill count reset by rst, IDLE and TIMEOUT.
//   period_valid only once 4 raw measurements since (re)lock, then on every raw measurement;
//   output registered one extra cycle (strobe 1 clk later than non-AVG). locked unchanged.
//  Not defined: period = raw measurement as above; no history/sum logic instantiated.
// STRUCTURE
//  prescaler_lib (shared package) gains: typedef enum {PM_IDLE, PM_MEASURE, PM_TIMEOUT} pm_state_t;
//   localparam PM_AVG_DEPTH = 4; localparam PM_AVG_SHIFT = 2.
//  Sub-module edge_sync_m (clk, rst, async_in -> sync_out, rise): synchroniser + rising-edge
//   detector, parameter STAGES; reusable by other input-sampling blocks.
//  Top holds FSM, saturating counter, output registers, optional averaging.
// TESTING
//  1 rst=1 during MEASURE with counter mid-count -> all outputs 0 immediately, before next posedge.
//  2 sig_in square wave 8 high/8 low, PERIOD_W=16 -> 1st valid after 2nd edge, period=16,
//    strobe every 16 clk, locked=1, timeout=0.
//  3 PERIOD_W=8, sig_in held low after lock -> timeout=1, locked=0 exactly 255 clk after last
//    counter reload; resume square wave 16 -> no valid on 1st edge, valid period=16 on 2nd.
//  4 switch period 16 -> 24 mid-run -> next strobe reports exactly 24 (plus one transitional value
//    equal to cycles between last old-rise and first new-rise), no missed/duplicated strobe.
//  5 PERIOD_W=4, period exactly 15 -> edge coincides with saturation -> period=15, valid, timeout=0.
//  6 PERIOD_METER_AVG_EN: raw periods 16,16,16,20 -> no strobe for first three, 4th strobe period=17.

Source files
------------

// File: rtl/prescaler_lib_pkg.sv
// Shared types for the prescaler / period meter pair.
// PERIOD_METER_AVG_EN selects the 4-sample averaged period output in period_meter_m.
package prescaler_lib;

  typedef enum logic [1:0] {
    PM_IDLE    = 2'd0,
    PM_MEASURE = 2'd1,
    PM_TIMEOUT = 2'd2
  } pm_state_t;

  localparam int unsigned PM_AVG_DEPTH = 4;
  localparam int unsigned PM_AVG_SHIFT = 2;

endpackage

// File: rtl/period_meter_m_if.sv
// Signal-under-test input and measurement results of period_meter_m.
interface period_meter_m_if #(
  parameter int unsigned PERIOD_W = 16
);
  logic                sig_in;
  logic [PERIOD_W-1:0] period;
  logic                period_valid;
  logic                locked;
  logic                timeout;

  modport master (output sig_in, input period, period_valid, locked, timeout);
  modport slave  (input sig_in, output period, period_valid, locked, timeout);
endinterface

// File: rtl/period_meter_m_edge_sync.sv
// edge_sync_m: STAGES-deep synchroniser followed by a registered rising-edge detector.
module edge_sync_m #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;
  logic              rise_q, rise_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], async_in};
    prev_d = sync_q[STAGES-1];
    rise_d = sync_q[STAGES-1] & ~prev_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  assign sync_out = sync_q[STAGES-1];
  assign rise     = rise_q;

endmodule

// File: rtl/period_meter_m.sv
// Measures the rise-to-rise period of an asynchronous input in clk cycles, with loss-of-signal timeout.
// Define PERIOD_METER_AVG_EN to report the floor mean of the last 4 raw periods instead.
module period_meter_m
  import prescaler_lib::*;
#(
  parameter int unsigned PERIOD_W    = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  period_meter_m_if.slave  bus
);

  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;

  logic                rise;
  pm_state_t           state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] raw_period_q, raw_period_d;
  logic                raw_valid_q, raw_valid_d;
  logic                locked_q, locked_d;
  logic                timeout_q, timeout_d;

  edge_sync_m #(.STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (bus.sig_in),
    .sync_out (),
    .rise     (rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= PM_IDLE;
      cnt_q        <= '0;
      raw_period_q <= '0;
      raw_valid_q  <= 1'b0;
      locked_q     <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      raw_period_q <= raw_period_d;
      raw_valid_q  <= raw_valid_d;
      locked_q     <= locked_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PM_IDLE:    if (rise) state_d = PM_MEASURE;
      PM_MEASURE: if (!rise && (cnt_q == CNT_MAX)) state_d = PM_TIMEOUT;
      PM_TIMEOUT: if (rise) state_d = PM_MEASURE;
      default:    state_d = PM_IDLE;
    endcase
  end

  // An edge always beats saturation, so a period of exactly CNT_MAX is still reported.
  always_comb begin
    cnt_d        = cnt_q;
    raw_period_d = raw_period_q;
    raw_valid_d  = 1'b0;
    locked_d     = locked_q;
    timeout_d    = timeout_q;
    case (state_q)
      PM_IDLE: begin
        cnt_d = rise ? PERIOD_W'(1) : '0;
      end
      PM_MEASURE: begin
        if (rise) begin
          raw_period_d = cnt_q;
          raw_valid_d  = 1'b1;
          locked_d     = 1'b1;
          cnt_d        = PERIOD_W'(1);
        end else if (cnt_q == CNT_MAX) begin
          timeout_d = 1'b1;
          locked_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + PERIOD_W'(1);
        end
      end
      PM_TIMEOUT: begin
        cnt_d = CNT_MAX;
        if (rise) begin
          cnt_d     = PERIOD_W'(1);
          timeout_d = 1'b0;
        end
      end
      default: begin
        cnt_d     = '0;
        locked_d  = 1'b0;
        timeout_d = 1'b0;
      end
    endcase
  end

`ifdef PERIOD_METER_AVG_EN
  localparam int unsigned SUM_W  = PERIOD_W + 2;
  localparam int unsigned FILL_W = 3;

  logic [PM_AVG_DEPTH-1:0][PERIOD_W-1:0] hist_q, hist_d;
  logic [SUM_W-1:0]                      sum_q, sum_d;
  logic [FILL_W-1:0]                     fill_q, fill_d;
  logic [PERIOD_W-1:0]                   avg_q, avg_d;
  logic                                  avg_valid_q, avg_valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q      <= '0;
      sum_q       <= '0;
      fill_q      <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      hist_q      <= hist_d;
      sum_q       <= sum_d;
      fill_q      <= fill_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
    end
  end

  // History restarts whenever lock is lost, so stale samples never leak into a new mean.
  always_comb begin
    hist_d      = hist_q;
    sum_d       = sum_q;
    fill_d      = fill_q;
    avg_d       = avg_q;
    avg_valid_d = 1'b0;
    if (state_q != PM_MEASURE) begin
      hist_d = '0;
      sum_d  = '0;
      fill_d = '0;
    end else if (raw_valid_q) begin
      sum_d  = sum_q + SUM_W'(raw_period_q) - SUM_W'(hist_q[PM_AVG_DEPTH-1]);
      hist_d = {hist_q[PM_AVG_DEPTH-2:0], raw_period_q};
      if (fill_q < FILL_W'(PM_AVG_DEPTH)) fill_d = fill_q + FILL_W'(1);
      if (fill_q >= FILL_W'(PM_AVG_DEPTH - 1)) begin
        avg_valid_d = 1'b1;
        avg_d       = sum_d[SUM_W-1:PM_AVG_SHIFT];
      end
    end
  end

  assign bus.period       = avg_q;
  assign bus.period_valid = avg_valid_q;
`else
  assign bus.period       = raw_period_q;
  assign bus.period_valid = raw_valid_q;
`endif

  assign bus.locked  = locked_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_period_meter_m.sv
// Scoreboard bench for period_meter_m: three instances (PERIOD_W 16, 8, 4) driven by directed pulse trains.
module tb_period_meter_m;

  typedef struct {
    int period;
    bit chk_gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sig_drv [3];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  exp_t sbq [3][$];
  int   last_rise [3];
  bit   has_last [3];
  int   meas [3];
  int   hist [3][4];
  int   last_strobe [3];

  logic [15:0] mon_period [3];
  logic        mon_valid [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  period_meter_m_if #(.PERIOD_W(16)) if16 ();
  period_meter_m_if #(.PERIOD_W(8))  if8 ();
  period_meter_m_if #(.PERIOD_W(4))  if4 ();

  period_meter_m #(.PERIOD_W(16), .SYNC_STAGES(2)) u16 (.clk(clk), .rst(rst), .bus(if16));
  period_meter_m #(.PERIOD_W(8),  .SYNC_STAGES(2)) u8  (.clk(clk), .rst(rst), .bus(if8));
  period_meter_m #(.PERIOD_W(4),  .SYNC_STAGES(2)) u4  (.clk(clk), .rst(rst), .bus(if4));

  assign if16.sig_in = sig_drv[0];
  assign if8.sig_in  = sig_drv[1];
  assign if4.sig_in  = sig_drv[2];

  assign mon_period[0] = if16.period;
  assign mon_period[1] = {8'd0, if8.period};
  assign mon_period[2] = {12'd0, if4.period};
  assign mon_valid[0]  = if16.period_valid;
  assign mon_valid[1]  = if8.period_valid;
  assign mon_valid[2]  = if4.period_valid;

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int max_of(input int d);
    case (d)
      0:       return 65535;
      1:       return 255;
      default: return 15;
    endcase
  endfunction

  task automatic push_raw(input int d, input int raw);
    exp_t e;
    meas[d]++;
`ifdef PERIOD_METER_AVG_EN
    for (int i = 3; i > 0; i--) hist[d][i] = hist[d][i-1];
    hist[d][0] = raw;
    if (meas[d] >= 4) begin
      e.period  = (hist[d][0] + hist[d][1] + hist[d][2] + hist[d][3]) / 4;
      e.chk_gap = (meas[d] > 4);
      sbq[d].push_back(e);
    end
`else
    e.period  = raw;
    e.chk_gap = (meas[d] > 1);
    sbq[d].push_back(e);
`endif
  endtask

  // A rise after a gap longer than the counter range restarts measurement without a strobe.
  task automatic model_rise(input int d);
    if (has_last[d] && (cyc - last_rise[d]) <= max_of(d)) push_raw(d, cyc - last_rise[d]);
    else meas[d] = 0;
    last_rise[d] = cyc;
    has_last[d]  = 1'b1;
  endtask

  task automatic pulse(input int d, input int h, input int l);
    @(posedge clk); #1;
    sig_drv[d] = 1'b1;
    model_rise(d);
    repeat (h) @(posedge clk);
    #1 sig_drv[d] = 1'b0;
    repeat (l - 1) @(posedge clk);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      has_last[d] = 1'b0;
      meas[d]     = 0;
      sbq[d].delete();
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        if (mon_valid[d]) begin
          if (sbq[d].size() == 0) begin
            check($sformatf("unexpected_strobe[%0d]", d), int'(mon_period[d]), -1);
          end else begin
            exp_t e;
            e = sbq[d].pop_front();
            check($sformatf("period[%0d]", d), int'(mon_period[d]), e.period);
            if (e.chk_gap) check($sformatf("strobe_gap[%0d]", d), cyc - last_strobe[d], e.period);
          end
          last_strobe[d] = cyc;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int d = 0; d < 3; d++) begin
      sig_drv[d] = 1'b0;
      last_strobe[d] = 0;
      for (int i = 0; i < 4; i++) hist[d][i] = 0;
    end
    model_reset();

    // power-on reset takes effect without a clock edge
    #2 rst = 1'b1;
    #1;
    check("rst_period16", int'(if16.period), 0);
    check("rst_valid16", int'(if16.period_valid), 0);
    check("rst_locked4", int'(if4.locked), 0);
    check("rst_timeout8", int'(if8.timeout), 0);
    @(posedge clk); #3 rst = 1'b0;

    // reset in the middle of a measurement
    repeat (3) pulse(0, 8, 8);
    repeat (5) @(posedge clk);
    check("pre_rst_locked16", int'(if16.locked), 1);
    check("pre_rst_drained16", sbq[0].size(), 0);
    #3 rst = 1'b1;
    #1;
    check("async_rst_period16", int'(if16.period), 0);
    check("async_rst_valid16", int'(if16.period_valid), 0);
    check("async_rst_locked16", int'(if16.locked), 0);
    check("async_rst_timeout16", int'(if16.timeout), 0);
    model_reset();
    @(posedge clk); #3 rst = 1'b0;

    // steady 16-cycle square wave, then switch to 24
    repeat (6) pulse(0, 8, 8);
    check("sq16_locked", int'(if16.locked), 1);
    check("sq16_timeout", int'(if16.timeout), 0);
    repeat (4) pulse(0, 12, 12);
    check("sq24_locked", int'(if16.locked), 1);

    // loss of signal on the 8-bit meter, then recovery
    repeat (3) pulse(1, 8, 8);
    k = last_rise[1];
    while (cyc < k + 258) begin @(posedge clk); #1; end
    check("pre_to_timeout8", int'(if8.timeout), 0);
    check("pre_to_locked8", int'(if8.locked), 1);
    @(posedge clk); #1;
    check("to_timeout8", int'(if8.timeout), 1);
    check("to_locked8", int'(if8.locked), 0);
    repeat (3) pulse(1, 8, 8);
    check("resume_timeout8", int'(if8.timeout), 0);
    check("resume_locked8", int'(if8.locked), 1);

    // period equal to saturation value on the 4-bit meter
    repeat (5) pulse(2, 8, 7);
    check("sat_timeout4", int'(if4.timeout), 0);
    check("sat_locked4", int'(if4.locked), 1);

    // raw periods 16,16,16,20 after a fresh lock
    @(posedge clk); #3 rst = 1'b1;
    model_reset();
    @(posedge clk); #3 rst = 1'b0;
    repeat (3) pulse(0, 8, 8);
    pulse(0, 8, 12);
    pulse(0, 8, 8);
    repeat (10) @(posedge clk);
`ifdef PERIOD_METER_AVG_EN
    check("avg_period16", int'(if16.period), 17);
`else
    check("raw_last_period16", int'(if16.period), 20);
`endif

    for (int d = 0; d < 3; d++) check($sformatf("missed_strobes[%0d]", d), sbq[d].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
